// File: rtl/dice_pkg.sv
// dice_pkg: shared FSM state encoding and width helpers for the multi-die roller.
//   IDLE/ROLL/SETTLE/REPORT/SHOW : 3-bit state encoding
//   face_w(faces)                : bits needed to hold values 0..faces
//   sum_w(n, faces)              : bits needed to hold a total of n dice
package dice_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ROLL   = 3'd1,
        SETTLE = 3'd2,
        REPORT = 3'd3,
        SHOW   = 3'd4
    } state_t;

    function automatic int face_w(input int faces);
        return $clog2(faces + 1);
    endfunction

    function automatic int sum_w(input int n, input int faces);
        return $clog2(n * faces + 1);
    endfunction

endpackage

// File: rtl/dice_die.sv
// dice_die: one odometer digit with values 1..FACES, reset to 0.
//   clk, rst   : clock, synchronous active-high reset
//   step_en    : advance this die on the edge
//   force_one  : a die holding 0 jumps to 1 (first advance after reset)
//   value      : current face, 0 only after reset
//   wrap       : combinational carry, high when stepping from FACES back to 1
module dice_die
    import dice_pkg::*;
#(
    parameter int FACES  = 6,
    parameter int FACE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_en,
    input  logic              force_one,
    output logic [FACE_W-1:0] value,
    output logic              wrap
);

    assign wrap = step_en && value == FACE_W'(FACES);

    // Out-of-range values (0 or above FACES) recover to 1 without carrying.
    always_ff @(posedge clk) begin
        if (rst)
            value <= '0;
        else if (force_one && value == '0)
            value <= FACE_W'(1);
        else if (step_en)
            value <= (value == '0 || value >= FACE_W'(FACES)) ? FACE_W'(1) : value + FACE_W'(1);
    end

endmodule

// File: rtl/multi_dice_roller.sv
// multi_dice_roller: NUM_DICE odometer-chained dice that spin while button is held,
// settle with decelerating steps after release, then report their total.
//   clk, rst : clock, synchronous active-high reset
//   button   : debounced roll request
//   faces    : packed die values, die i at [i*FACE_W +: FACE_W]
//   sum      : latched total of all faces
//   valid    : one-cycle pulse when sum is fresh
//   busy     : high while rolling or settling
module multi_dice_roller
    import dice_pkg::*;
#(
    parameter int NUM_DICE     = 2,
    parameter int FACES        = 6,
    parameter int SETTLE_STEPS = 3,
    localparam int FACE_W      = face_w(FACES),
    localparam int SUM_W       = sum_w(NUM_DICE, FACES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       button,
    output logic [NUM_DICE*FACE_W-1:0] faces,
    output logic [SUM_W-1:0]           sum,
    output logic                       valid,
    output logic                       busy
);

    localparam int KW = (SETTLE_STEPS > 1) ? $clog2(SETTLE_STEPS) : 1;
    localparam int WW = (SETTLE_STEPS > 0) ? SETTLE_STEPS : 1;

    state_t          state, nxt;
    logic [KW-1:0]   k_cnt, k_nxt;
    logic [WW-1:0]   w_cnt, w_nxt;
    logic            advance, latch, any_zero, hit, last;
    logic [SUM_W-1:0] total;
    logic [NUM_DICE:0] carry;
    logic            unused_top_wrap;

    assign carry[0]        = advance;
    assign unused_top_wrap = carry[NUM_DICE];

    for (genvar i = 0; i < NUM_DICE; i++) begin : g_die
        dice_die #(.FACES(FACES), .FACE_W(FACE_W)) u_die (
            .clk       (clk),
            .rst       (rst),
            .step_en   (carry[i]),
            .force_one (advance & any_zero),
            .value     (faces[i*FACE_W +: FACE_W]),
            .wrap      (carry[i+1])
        );
    end

    always_comb begin
        total    = '0;
        any_zero = 1'b0;
        for (int i = 0; i < NUM_DICE; i++) begin
            total    = total + SUM_W'(faces[i*FACE_W +: FACE_W]);
            any_zero = any_zero | (faces[i*FACE_W +: FACE_W] == '0);
        end
    end

    // Settle step k fires once the wait counter reaches 2^k-1.
    assign hit  = int'(w_cnt) == (1 << int'(k_cnt)) - 1;
    assign last = int'(k_cnt) == SETTLE_STEPS - 1;

    always_comb begin
        nxt     = state;
        k_nxt   = k_cnt;
        w_nxt   = w_cnt;
        advance = 1'b0;
        latch   = 1'b0;
        if (button) begin
            nxt     = ROLL;
            advance = 1'b1;
            k_nxt   = '0;
            w_nxt   = '0;
        end else begin
            case (state)
                ROLL:   nxt = (SETTLE_STEPS == 0) ? REPORT : SETTLE;
                SETTLE: begin
                    if (hit) begin
                        advance = 1'b1;
                        w_nxt   = '0;
                        k_nxt   = last ? '0 : k_cnt + KW'(1);
                        nxt     = last ? REPORT : SETTLE;
                    end else begin
                        w_nxt = w_cnt + WW'(1);
                    end
                end
                REPORT: begin
                    latch = 1'b1;
                    nxt   = SHOW;
                end
                default: nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k_cnt <= '0;
            w_cnt <= '0;
            sum   <= '0;
            valid <= 1'b0;
        end else begin
            state <= nxt;
            k_cnt <= k_nxt;
            w_cnt <= w_nxt;
            valid <= latch;
            if (latch)
                sum <= total;
        end
    end

    assign busy = state == ROLL || state == SETTLE;

endmodule

// File: tb/tb_multi_dice_roller.sv
// tb_multi_dice_roller: directed vector bench for the default 2x6 roller and a 3x4 no-settle variant.
module tb_multi_dice_roller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button = 1'b0;
    logic       button2 = 1'b0;
    logic [5:0] faces;
    logic [3:0] sum;
    logic       valid, busy;
    logic [8:0] faces2;
    logic [3:0] sum2;
    logic       valid2, busy2;
    int         n_vec = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    multi_dice_roller dut (
        .clk(clk), .rst(rst), .button(button),
        .faces(faces), .sum(sum), .valid(valid), .busy(busy)
    );

    multi_dice_roller #(.NUM_DICE(3), .FACES(4), .SETTLE_STEPS(0)) dut2 (
        .clk(clk), .rst(rst), .button(button2),
        .faces(faces2), .sum(sum2), .valid(valid2), .busy(busy2)
    );

    typedef struct {
        int r;
        int b;
        int f;
        int s;
        int v;
        int bz;
    } vec_t;

    vec_t tv[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input string tag, input int r, input int b, input int f, input int s,
                       input int v, input int bz);
        rst    = (r != 0);
        button = (b != 0);
        @(posedge clk);
        #1;
        chk({tag, ".faces"}, 32'(faces), f);
        chk({tag, ".sum"}, 32'(sum), s);
        chk({tag, ".valid"}, 32'(valid), v);
        chk({tag, ".busy"}, 32'(busy), bz);
    endtask

    task automatic edge2(input logic b);
        button2 = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0, d1;
        int d[3];
        int s_exp;
        // faces value for {d1,d0} is d1*8+d0
        tv[0]  = '{1, 0, 0, 0, 0, 0};
        tv[1]  = '{1, 0, 0, 0, 0, 0};
        tv[2]  = '{0, 0, 0, 0, 0, 0};
        tv[3]  = '{0, 1, 9, 0, 0, 1};
        tv[4]  = '{0, 0, 9, 0, 0, 1};
        tv[5]  = '{0, 0, 10, 0, 0, 1};
        tv[6]  = '{0, 0, 10, 0, 0, 1};
        tv[7]  = '{0, 0, 11, 0, 0, 1};
        tv[8]  = '{0, 0, 11, 0, 0, 1};
        tv[9]  = '{0, 0, 11, 0, 0, 1};
        tv[10] = '{0, 0, 11, 0, 0, 1};
        tv[11] = '{0, 0, 12, 0, 0, 0};
        tv[12] = '{0, 0, 12, 5, 1, 0};
        tv[13] = '{0, 0, 12, 5, 0, 0};
        tv[14] = '{1, 0, 0, 0, 0, 0};
        tv[15] = '{0, 1, 9, 0, 0, 1};
        tv[16] = '{0, 1, 10, 0, 0, 1};
        tv[17] = '{0, 1, 11, 0, 0, 1};
        tv[18] = '{0, 1, 12, 0, 0, 1};
        tv[19] = '{0, 1, 13, 0, 0, 1};
        tv[20] = '{0, 1, 14, 0, 0, 1};
        tv[21] = '{0, 1, 17, 0, 0, 1};
        tv[22] = '{1, 1, 0, 0, 0, 0};
        tv[23] = '{1, 1, 0, 0, 0, 0};
        tv[24] = '{0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 25; i++)
            cyc($sformatf("vec%0d", i), tv[i].r, tv[i].b, tv[i].f, tv[i].s, tv[i].v, tv[i].bz);

        // full odometer period: 36 advances return to {1,1}
        cyc("odo_rst", 1, 0, 0, 0, 0, 0);
        cyc("odo_press", 0, 1, 9, 0, 0, 1);
        d0 = 1;
        d1 = 1;
        for (int i = 1; i <= 36; i++) begin
            d0++;
            if (d0 > 6) begin
                d0 = 1;
                d1 = (d1 == 6) ? 1 : d1 + 1;
            end
            cyc($sformatf("odo%0d", i), 0, 1, d1 * 8 + d0, 0, 0, 1);
        end
        chk("odo_period", 32'(faces), 9);

        // interrupted settle, then a full settle restarting at k=0
        cyc("int_rst", 1, 0, 0, 0, 0, 0);
        cyc("int_press", 0, 1, 9, 0, 0, 1);
        cyc("int_R", 0, 0, 9, 0, 0, 1);
        cyc("int_R1", 0, 0, 10, 0, 0, 1);
        cyc("int_R2", 0, 1, 11, 0, 0, 1);
        cyc("re_R", 0, 0, 11, 0, 0, 1);
        cyc("re_R1", 0, 0, 12, 0, 0, 1);
        cyc("re_R2", 0, 0, 12, 0, 0, 1);
        cyc("re_R3", 0, 0, 13, 0, 0, 1);
        cyc("re_R4", 0, 0, 13, 0, 0, 1);
        cyc("re_R5", 0, 0, 13, 0, 0, 1);
        cyc("re_R6", 0, 0, 13, 0, 0, 1);
        cyc("re_R7", 0, 0, 14, 0, 0, 0);
        cyc("re_R8", 0, 0, 14, 7, 1, 0);

        // re-roll from SHOW: carry into die 1, old sum holds until next REPORT
        cyc("show_press", 0, 1, 17, 7, 0, 1);
        cyc("show_R", 0, 0, 17, 7, 0, 1);
        cyc("show_R1", 0, 0, 18, 7, 0, 1);
        cyc("show_R2", 0, 0, 18, 7, 0, 1);
        cyc("show_R3", 0, 0, 19, 7, 0, 1);
        cyc("show_R4", 0, 0, 19, 7, 0, 1);
        cyc("show_R5", 0, 0, 19, 7, 0, 1);
        cyc("show_R6", 0, 0, 19, 7, 0, 1);
        cyc("show_R7", 0, 0, 20, 7, 0, 0);
        cyc("show_R8", 0, 0, 20, 6, 1, 0);
        cyc("show_R9", 0, 0, 20, 6, 0, 0);

        // 3 dice x 4 faces, no settle: faces value is d2*64+d1*8+d0
        rst = 1'b1;
        edge2(1'b0);
        chk("c_rst.faces", 32'(faces2), 0);
        chk("c_rst.sum", 32'(sum2), 0);
        chk("c_rst.busy", 32'(busy2), 0);
        rst = 1'b0;
        edge2(1'b1);
        chk("c_p1", 32'(faces2), 73);
        edge2(1'b1);
        chk("c_p2", 32'(faces2), 74);
        edge2(1'b1);
        chk("c_p3", 32'(faces2), 75);
        edge2(1'b1);
        chk("c_p4", 32'(faces2), 76);
        edge2(1'b1);
        chk("c_p5", 32'(faces2), 81);
        chk("c_p5.busy", 32'(busy2), 1);
        edge2(1'b0);
        chk("c_R.faces", 32'(faces2), 81);
        chk("c_R.valid", 32'(valid2), 0);
        chk("c_R.busy", 32'(busy2), 0);
        edge2(1'b0);
        chk("c_R1.valid", 32'(valid2), 1);
        chk("c_R1.sum", 32'(sum2), 4);
        edge2(1'b0);
        chk("c_R2.valid", 32'(valid2), 0);
        chk("c_R2.sum", 32'(sum2), 4);

        d[0] = 1;
        d[1] = 2;
        d[2] = 1;
        for (int i = 0; i < 20; i++) begin
            edge2(1'b1);
            d[0]++;
            if (d[0] > 4) begin
                d[0] = 1;
                d[1]++;
                if (d[1] > 4) begin
                    d[1] = 1;
                    d[2] = (d[2] == 4) ? 1 : d[2] + 1;
                end
            end
            chk($sformatf("c_roll%0d", i), 32'(faces2), d[2] * 64 + d[1] * 8 + d[0]);
            for (int j = 0; j < 3; j++)
                chk($sformatf("c_range%0d_%0d", i, j),
                    32'(faces2[j*3 +: 3] >= 3'd1 && faces2[j*3 +: 3] <= 3'd4), 1);
        end
        s_exp = d[0] + d[1] + d[2];
        edge2(1'b0);
        chk("c_fin_R.valid", 32'(valid2), 0);
        edge2(1'b0);
        chk("c_fin.valid", 32'(valid2), 1);
        chk("c_fin.sum", 32'(sum2), s_exp);
        chk("c_fin.sum_range", 32'(sum2 >= 4'd3 && sum2 <= 4'd12), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_dice_roller.md
Name: multi_dice_roller

Overview:
- Parametrised successor to the single electronic die: NUM_DICE dice with FACES faces each, chained as an odometer.
- While the button is held, the dice spin every cycle. On release, a decelerating settle phase runs, then the block reports a sum with a one-cycle valid pulse.
- Sits between the debounced button input and the display/score logic.

Parameters:
- NUM_DICE, 2, number of dice (>=1).
- FACES, 6, faces per die (>=2); legal values 1..FACES.
- SETTLE_STEPS, 3, number of decelerating advances after release; 0 disables settle.
- Derived (localparam): FACE_W = $clog2(FACES+1); SUM_W = $clog2(NUM_DICE*FACES+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- button  in  1  roll request, already debounced and synchronous.
- faces  out  NUM_DICE*FACE_W  die values, packed; die i at [i*FACE_W +: FACE_W], die 0 least significant.
- sum  out  SUM_W  latched total of all faces.
- valid  out  1  one-cycle pulse when sum is fresh.
- busy  out  1  high in ROLL or SETTLE.

Behaviour:
- Reset: state IDLE, all faces 0, sum 0, valid 0, busy 0, settle counters 0. Reset mid-roll or mid-settle gives the same result on the next edge.
- Advance (odometer step), die by die:
  - Die 0 always steps.
  - Die i>0 steps only when die i-1 wrapped on this edge.
  - Step rule: value 0 or >FACES becomes 1, with no carry out. Value FACES becomes 1 with carry out. Otherwise value+1.
  - Exception: while any die is 0, each advance forces every die that is 0 to 1 simultaneously. After reset, the first advance therefore gives all ones.
- Faces hold their value in every state except on an advance edge.
- FSM states: IDLE, ROLL, SETTLE, REPORT, SHOW.
- Button priority: in IDLE, SETTLE, REPORT or SHOW, button=1 at an edge moves to ROLL and advances on that same edge. Settle counters clear and no valid is issued.
- ROLL:
  - button=1: stay and advance every edge.
  - button=0: go to SETTLE with no advance (k=0, wait=0).
  - If SETTLE_STEPS=0, button=0 goes directly to REPORT.
- SETTLE timing: step k advances when wait == 2^k-1, then k++ and wait=0; otherwise wait++. With release edge R and SETTLE_STEPS=3, advances occur at R+1, R+3 and R+7. The last advance edge also moves to REPORT.
- REPORT: one cycle; faces stable. The next edge latches sum = sum of all faces (SUM_W wide, no overflow possible), sets valid=1 and moves to SHOW.
- SHOW: valid is high only on the first SHOW cycle. Faces and sum hold until button.
- Wait counter width: SETTLE_STEPS bits, sufficient for 2^(SETTLE_STEPS-1)-1.
- All outputs are registered. busy is decoded from the state register.

Decomposition:
- dice_pkg:
  - FSM state localparams (3-bit encoding).
  - Constant function clog2 if the tool needs it.
  - Helper constants for FACE_W/SUM_W computation.
- Sub-module dice_die, instantiated NUM_DICE times by generate:
  - Inputs: clk, rst, step_en, force_one.
  - Outputs: value[FACE_W], wrap.
  - Implements the step rule and reset to 0.
  - Die i step_en = advance & (i==0 | wrap of die i-1).
- The top level holds the FSM, settle counters and sum adder.

Test Plan:
- Reset: assert rst 2 cycles mid-roll -> faces=0, sum=0, valid=0, busy=0; IDLE retained with button=0.
- Single tap (NUM_DICE=2, FACES=6): after reset, button=1 for one edge then 0 -> faces {d1,d0}={1,1} after the press. Settle advances at R+1/R+3/R+7 give d0=2,3,4. valid=1 for exactly one cycle at R+8 with sum=5, faces {1,4}.
- Odometer carry: hold button 7 edges from reset -> {1,1},{1,2}..{1,6}, then {2,1}. 36 further advances return the faces to the same value; busy=1 throughout.
- Interrupt settle: release, then button=1 at R+2 -> immediate advance and return to ROLL. No valid pulse; settle restarts (k=0) at the next release.
- Re-roll from SHOW: button during SHOW -> ROLL with advance on the same edge, valid stays 0, sum holds its old value until the next REPORT.
- Config sweep: NUM_DICE=3, FACES=4, SETTLE_STEPS=0 -> release goes ROLL->REPORT->SHOW. valid occurs 2 edges after release; faces are always within 1..4 after the first press; sum is in 3..12.
